rf_write_arbiter: RTL and testbench

Shares the register file's single write port (WE3/A3/WD3) between the pipeline writeback stage and a multicycle unit (divider, long-latency load). Pipeline writebacks always win the port. Multicycle results queue in a small FIFO and drain into idle write cycles. Address-0 writes are discarded, and a starvation counter requests a one-cycle writeback bubble when a queued result has waited too long.

---
 rtl/rf_write_arbiter_if.sv | 30 +++
 rtl/rf_write_arbiter.sv | 115 +++++++++++
 tb/tb_rf_write_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// Write-port bus between the pipeline/multicycle requesters and the register-file write arbiter.
// The requesters drive the master side; the arbiter is the slave.
interface rf_write_arbiter_if #(
  parameter int addWidth  = 5,
  parameter int dataWidth = 32,
  parameter int fifoDepth = 2
);
  logic                           WBE;
  logic [addWidth-1:0]            WBA;
  logic [dataWidth-1:0]           WBD;
  logic                           MCV;
  logic [addWidth-1:0]            MCA;
  logic [dataWidth-1:0]           MCD;
  logic                           MCR;
  logic                           WE3;
  logic [addWidth-1:0]            A3;
  logic [dataWidth-1:0]           WD3;
  logic [$clog2(fifoDepth+1)-1:0] PEND;
  logic                           WBSTALL;

  modport master (
    output WBE, WBA, WBD, MCV, MCA, MCD,
    input  MCR, WE3, A3, WD3, PEND, WBSTALL
  );

  modport slave (
    input  WBE, WBA, WBD, MCV, MCA, MCD,
    output MCR, WE3, A3, WD3, PEND, WBSTALL
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline writebacks win the port, and multicycle results
// queue in a small FIFO that drains into idle cycles, with WAW squash and starvation stall.
module rf_write_arbiter #(
  parameter int addWidth    = 5,
  parameter int dataWidth   = 32,
  parameter int fifoDepth   = 2,
  parameter int starveLimit = 8
) (
  input logic             CLK,
  input logic             RSTn,
  rf_write_arbiter_if.slave bus
);
  localparam int PW = $clog2(fifoDepth);
  localparam int CW = $clog2(fifoDepth + 1);
  localparam int AW = $clog2(starveLimit + 1);

  typedef struct packed {
    logic                 valid;
    logic [addWidth-1:0]  addr;
    logic [dataWidth-1:0] data;
  } entry_t;

  entry_t               mem_q [fifoDepth];
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [AW-1:0]        age_q, age_d;
  logic                 stall_q, stall_d;
  logic                 we_q, we_d;
  logic [addWidth-1:0]  a3_q, a3_d;
  logic [dataWidth-1:0] wd3_q, wd3_d;

  entry_t head;
  logic   pipe_wr, head_present, head_valid, issue_head, pop, enq, enq_valid;

  assign head         = mem_q[rd_ptr_q];
  assign head_present = (count_q != '0);
  assign head_valid   = head_present && head.valid;
  assign pipe_wr      = bus.WBE && (bus.WBA != '0);
  assign issue_head   = !pipe_wr && head_valid;
  // A squashed head leaves on any edge, even one where the pipeline owns the port.
  assign pop          = head_present && (issue_head || !head.valid);
  assign enq          = bus.MCV && bus.MCR;
  assign enq_valid    = (bus.MCA != '0) && !(pipe_wr && (bus.MCA == bus.WBA));

  assign bus.MCR     = (count_q != CW'(fifoDepth));
  assign bus.WE3     = we_q;
  assign bus.A3      = a3_q;
  assign bus.WD3     = wd3_q;
  assign bus.PEND    = count_q;
  assign bus.WBSTALL = stall_q;

  always_comb begin
    // NOTE: every _d gets a default first so no path through this block can infer a latch.
    we_d     = 1'b0;
    a3_d     = a3_q;
    wd3_d    = wd3_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    age_d    = age_q;

    if (pipe_wr) begin
      we_d  = 1'b1;
      a3_d  = bus.WBA;
      wd3_d = bus.WBD;
    end else if (issue_head) begin
      we_d  = 1'b1;
      a3_d  = head.addr;
      wd3_d = head.data;
    end

    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
    if (enq && !pop)      count_d = count_q + CW'(1);
    else if (!enq && pop) count_d = count_q - CW'(1);

    if (pop || !head_present) age_d = '0;
    else if (head_valid && age_q != AW'(starveLimit)) age_d = age_q + AW'(1);

    // Stall is held only while the same valid head is still waiting for the port.
    stall_d = (head_valid && !issue_head && age_q == AW'(starveLimit - 1)) ||
              (stall_q && head_valid && !issue_head);
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      we_q     <= 1'b0;
      a3_q     <= '0;
      wd3_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      age_q    <= '0;
      stall_q  <= 1'b0;
    end else begin
      we_q     <= we_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      age_q    <= age_d;
      stall_q  <= stall_d;
    end
  end

  // NOTE: queue storage is not reset; count_q alone decides which slots are meaningful.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < fifoDepth; i++) begin
      if (pipe_wr && mem_q[i].addr == bus.WBA) mem_q[i].valid <= 1'b0;
    end
    if (enq) mem_q[wr_ptr_q] <= '{valid: enq_valid, addr: bus.MCA, data: bus.MCD};
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scenario bench for rf_write_arbiter: expected register-file writes go into a queue when
// stimulus is driven and are popped by a monitor whenever WE3 is seen.
module tb_rf_write_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  always #5 clk = ~clk;

  rf_write_arbiter_if #(.addWidth(5), .dataWidth(32), .fifoDepth(2)) bus ();

  rf_write_arbiter #(
    .addWidth(5), .dataWidth(32), .fifoDepth(2), .starveLimit(8)
  ) dut (
    .CLK (clk),
    .RSTn(rst_n),
    .bus (bus.slave)
  );

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus.WBE = 1'b0; bus.WBA = '0; bus.WBD = '0;
    bus.MCV = 1'b0; bus.MCA = '0; bus.MCD = '0;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  task automatic pipe(input logic [4:0] a, input logic [31:0] d);
    bus.WBE = 1'b1; bus.WBA = a; bus.WBD = d;
    if (a != 5'd0) push(a, d);
  endtask

  task automatic mc(input logic [4:0] a, input logic [31:0] d);
    bus.MCV = 1'b1; bus.MCA = a; bus.MCD = d;
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.WE3 === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got A3=%0d WD3=%h, expected no write", bus.A3, bus.WD3);
        end else begin
          e = exp_q.pop_front();
          if (bus.A3 !== e.addr || bus.WD3 !== e.data) begin
            bad++;
            $display("FAIL write_value: got A3=%0d WD3=%h, expected A3=%0d WD3=%h",
                     bus.A3, bus.WD3, e.addr, e.data);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    repeat (3) cyc();
    total++;
    if (bus.MCR !== 1'b1) begin bad++; $display("FAIL reset_mcr_in_reset: got %b expected 1", bus.MCR); end
    rst_n = 1'b1;
    cyc();
    total++; if (bus.WE3 !== 1'b0)     begin bad++; $display("FAIL reset_we3: got %b expected 0", bus.WE3); end
    total++; if (bus.A3 !== 5'd0)      begin bad++; $display("FAIL reset_a3: got %0d expected 0", bus.A3); end
    total++; if (bus.WD3 !== 32'd0)    begin bad++; $display("FAIL reset_wd3: got %h expected 0", bus.WD3); end
    total++; if (bus.MCR !== 1'b1)     begin bad++; $display("FAIL reset_mcr: got %b expected 1", bus.MCR); end
    total++; if (bus.PEND !== 2'd0)    begin bad++; $display("FAIL reset_pend: got %0d expected 0", bus.PEND); end
    total++; if (bus.WBSTALL !== 1'b0) begin bad++; $display("FAIL reset_wbstall: got %b expected 0", bus.WBSTALL); end
  endtask

  task automatic test_priority();
    pipe(5'd3, 32'hAAAA);
    mc(5'd4, 32'hBBBB);
    cyc();
    total++; if (bus.PEND !== 2'd1) begin bad++; $display("FAIL prio_pend1: got %0d expected 1", bus.PEND); end
    idle();
    push(5'd4, 32'hBBBB);
    cyc();
    total++; if (bus.PEND !== 2'd0) begin bad++; $display("FAIL prio_pend0: got %0d expected 0", bus.PEND); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL prio_drain: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_full();
    pipe(5'd10, 32'h10); mc(5'd20, 32'h2020);
    cyc();
    total++; if (bus.PEND !== 2'd1) begin bad++; $display("FAIL full_pend1: got %0d expected 1", bus.PEND); end
    pipe(5'd11, 32'h11); mc(5'd21, 32'h2121);
    cyc();
    total++; if (bus.PEND !== 2'd2) begin bad++; $display("FAIL full_pend2: got %0d expected 2", bus.PEND); end
    total++; if (bus.MCR !== 1'b0)  begin bad++; $display("FAIL full_mcr0: got %b expected 0", bus.MCR); end
    pipe(5'd12, 32'h12); mc(5'd22, 32'h2222);
    cyc();
    total++; if (bus.PEND !== 2'd2) begin bad++; $display("FAIL full_reject: got %0d expected 2", bus.PEND); end
    idle();
    push(5'd20, 32'h2020);
    push(5'd21, 32'h2121);
    cyc();
    total++; if (bus.PEND !== 2'd1) begin bad++; $display("FAIL full_drain1: got %0d expected 1", bus.PEND); end
    cyc();
    total++; if (bus.PEND !== 2'd0) begin bad++; $display("FAIL full_drain2: got %0d expected 0", bus.PEND); end
    total++; if (bus.MCR !== 1'b1)  begin bad++; $display("FAIL full_mcr1: got %b expected 1", bus.MCR); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL full_left: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_squash();
    mc(5'd7, 32'h1111);
    cyc();
    idle();
    pipe(5'd7, 32'h2222);
    cyc();
    total++; if (bus.PEND !== 2'd1) begin bad++; $display("FAIL squash_pend1: got %0d expected 1", bus.PEND); end
    idle();
    cyc();
    total++; if (bus.WE3 !== 1'b0)  begin bad++; $display("FAIL squash_pop_we3: got %b expected 0", bus.WE3); end
    total++; if (bus.PEND !== 2'd0) begin bad++; $display("FAIL squash_pend0: got %0d expected 0", bus.PEND); end
    // Same-edge enqueue and pipeline write to one address.
    pipe(5'd9, 32'h9999); mc(5'd9, 32'h0909);
    cyc();
    total++; if (bus.PEND !== 2'd1) begin bad++; $display("FAIL squash_same_pend1: got %0d expected 1", bus.PEND); end
    idle();
    cyc();
    total++; if (bus.WE3 !== 1'b0)  begin bad++; $display("FAIL squash_same_we3: got %b expected 0", bus.WE3); end
    total++; if (bus.PEND !== 2'd0) begin bad++; $display("FAIL squash_same_pend0: got %0d expected 0", bus.PEND); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL squash_left: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_addr_zero();
    pipe(5'd6, 32'h6666); mc(5'd5, 32'h5555);
    cyc();
    pipe(5'd0, 32'hBEEF); mc(5'd0, 32'hDEAD);
    push(5'd5, 32'h5555);
    cyc();
    total++; if (bus.PEND !== 2'd1) begin bad++; $display("FAIL zero_pend1: got %0d expected 1", bus.PEND); end
    idle();
    cyc();
    total++; if (bus.WE3 !== 1'b0)  begin bad++; $display("FAIL zero_pop_we3: got %b expected 0", bus.WE3); end
    total++; if (bus.PEND !== 2'd0) begin bad++; $display("FAIL zero_pend0: got %0d expected 0", bus.PEND); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL zero_left: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_starve();
    logic exp_stall;
    pipe(5'd1, 32'h100); mc(5'd15, 32'hCAFE);
    cyc();
    bus.MCV = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      pipe(5'(k + 1), 32'h200 + 32'(k));
      cyc();
      exp_stall = (k == 8);
      total++;
      if (bus.WBSTALL !== exp_stall) begin
        bad++; $display("FAIL starve_stall_edge%0d: got %b expected %b", k, bus.WBSTALL, exp_stall);
      end
    end
    idle();
    push(5'd15, 32'hCAFE);
    cyc();
    total++; if (bus.WBSTALL !== 1'b0) begin bad++; $display("FAIL starve_clear: got %b expected 0", bus.WBSTALL); end
    total++; if (bus.PEND !== 2'd0)    begin bad++; $display("FAIL starve_pend0: got %0d expected 0", bus.PEND); end
    total++; if (exp_q.size() != 0)    begin bad++; $display("FAIL starve_left: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_async_reset();
    pipe(5'd2, 32'h22); mc(5'd17, 32'h1717);
    cyc();
    pipe(5'd3, 32'h33); mc(5'd18, 32'h1818);
    cyc();
    total++; if (bus.PEND !== 2'd2) begin bad++; $display("FAIL areset_pre_pend: got %0d expected 2", bus.PEND); end
    idle();
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.PEND !== 2'd0) begin bad++; $display("FAIL areset_pend: got %0d expected 0", bus.PEND); end
    total++; if (bus.WE3 !== 1'b0)  begin bad++; $display("FAIL areset_we3: got %b expected 0", bus.WE3); end
    total++; if (bus.MCR !== 1'b1)  begin bad++; $display("FAIL areset_mcr: got %b expected 1", bus.MCR); end
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
    total++; if (bus.PEND !== 2'd0) begin bad++; $display("FAIL areset_post_pend: got %0d expected 0", bus.PEND); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL areset_left: got %0d left expected 0", exp_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    fork
      monitor();
    join_none
    test_reset();
    test_priority();
    test_full();
    test_squash();
    test_addr_zero();
    test_starve();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
